// File: rtl/tuser_sched.sv
// Per-packet tuple scheduler: queues SDNet tuples and stamps one onto every beat
// of each AXIS packet, holding the head beat until its tuple is available.
module tuser_sched #(
  parameter int DATA_W  = 256,
  parameter int TUPLE_W = 128,
  parameter int TDEPTH  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                       tsch_aclk,
  input  logic                       tsch_arstn,
  input  logic                       s_tuple_valid,
  input  logic [TUPLE_W-1:0]         s_tuple_data,
  input  logic                       s_avalid,
  output logic                       s_aready,
  input  logic [DATA_W-1:0]          s_adata,
  input  logic                       s_alast,
  output logic                       m_avalid,
  input  logic                       m_aready,
  output logic [DATA_W-1:0]          m_adata,
  output logic                       m_alast,
  output logic [TUPLE_W-1:0]         m_atuser,
  output logic [$clog2(TDEPTH):0]    fifo_level,
  output logic [15:0]                drop_cnt,
  output logic                       err_timeout
);

  localparam int PW = $clog2(TDEPTH);
  localparam int LW = PW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {SOP, BODY} state_t;

  state_t               state, state_nxt;
  logic [TUPLE_W-1:0]   mem [TDEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic [TUPLE_W-1:0]   cur_tuple;
  logic [15:0]          drop_q;
  logic                 err_q;
  logic [WW-1:0]        wait_cnt;

  logic gate, xfer, pop, push, full, empty, hold;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [WW-1:0] sat_wait(input logic [WW-1:0] v);
    return (v == WW'(TIMEOUT)) ? v : v + WW'(1);
  endfunction

  assign empty    = (level == '0);
  assign full     = (level == LW'(TDEPTH));
  assign gate     = (state == BODY) || !empty;
  assign m_avalid = s_avalid & gate;
  assign s_aready = m_aready & gate;
  assign xfer     = s_avalid & s_aready;
  assign pop      = xfer && (state == SOP);
  // A full FIFO still accepts a tuple when the head is popped in the same cycle.
  assign push     = s_tuple_valid && (!full || pop);
  assign hold     = (state == SOP) && s_avalid && empty;

  assign m_adata     = s_adata;
  assign m_alast     = s_alast;
  assign m_atuser    = (state == BODY) ? cur_tuple : (empty ? '0 : mem[rd_ptr]);
  assign fifo_level  = level;
  assign drop_cnt    = drop_q;
  assign err_timeout = err_q;

  always_comb begin
    state_nxt = state;
    case (state)
      SOP:     if (xfer && !s_alast) state_nxt = BODY;
      BODY:    if (xfer && s_alast)  state_nxt = SOP;
      default: state_nxt = SOP;
    endcase
  end

  always_ff @(posedge tsch_aclk or negedge tsch_arstn) begin
    if (!tsch_arstn) begin
      state     <= SOP;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cur_tuple <= '0;
      drop_q    <= '0;
      err_q     <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        cur_tuple <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (s_tuple_valid && !push) drop_q <= sat_inc16(drop_q);
      if (hold) begin
        wait_cnt <= sat_wait(wait_cnt);
        if (wait_cnt >= WW'(TIMEOUT - 1)) err_q <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Tuple storage carries no reset; the level gates any stale contents.
  always_ff @(posedge tsch_aclk) begin
    if (push) mem[wr_ptr] <= s_tuple_data;
  end

endmodule

// File: tb/tb_tuser_sched.sv
// Self-checking bench for tuser_sched: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_tuser_sched;

  localparam int DATA_W  = 256;
  localparam int TUPLE_W = 128;
  localparam int TDEPTH  = 4;
  localparam int TIMEOUT = 100;
  localparam int LW      = $clog2(TDEPTH) + 1;

  logic               clk = 1'b0;
  logic               arstn;
  logic               s_tuple_valid;
  logic [TUPLE_W-1:0] s_tuple_data;
  logic               s_avalid;
  logic               s_aready;
  logic [DATA_W-1:0]  s_adata;
  logic               s_alast;
  logic               m_avalid;
  logic               m_aready;
  logic [DATA_W-1:0]  m_adata;
  logic               m_alast;
  logic [TUPLE_W-1:0] m_atuser;
  logic [LW-1:0]      fifo_level;
  logic [15:0]        drop_cnt;
  logic               err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [TUPLE_W-1:0] mq[$];
  bit                 mbody;
  logic [TUPLE_W-1:0] mcur;
  int                 mdrop;
  bit                 merr;
  int                 mwait;
  bit                 exp_mvalid, exp_sready;
  logic [TUPLE_W-1:0] exp_tuser;

  always #5 clk = ~clk;

  tuser_sched #(.DATA_W(DATA_W), .TUPLE_W(TUPLE_W), .TDEPTH(TDEPTH), .TIMEOUT(TIMEOUT)) dut (
    .tsch_aclk(clk), .tsch_arstn(arstn),
    .s_tuple_valid(s_tuple_valid), .s_tuple_data(s_tuple_data),
    .s_avalid(s_avalid), .s_aready(s_aready), .s_adata(s_adata), .s_alast(s_alast),
    .m_avalid(m_avalid), .m_aready(m_aready), .m_adata(m_adata), .m_alast(m_alast),
    .m_atuser(m_atuser), .fifo_level(fifo_level), .drop_cnt(drop_cnt),
    .err_timeout(err_timeout)
  );

  function automatic logic [TUPLE_W-1:0] rand_tuple();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    mq.delete();
    mbody = 0; mcur = '0; mdrop = 0; merr = 0; mwait = 0;
  endtask

  task automatic calc();
    bit open;
    open       = mbody || (mq.size() != 0);
    exp_mvalid = s_avalid && open;
    exp_sready = m_aready && open;
    exp_tuser  = mbody ? mcur : ((mq.size() != 0) ? mq[0] : '0);
  endtask

  // Advance one clock and apply the packet/tuple rules to the model.
  task automatic tick();
    bit xfer, waiting;
    calc();
    xfer    = s_avalid && exp_sready;
    waiting = !mbody && s_avalid && (mq.size() == 0);
    @(posedge clk);
    if (xfer && !mbody) begin
      mcur  = mq.pop_front();
      mbody = !s_alast;
    end else if (xfer && s_alast) begin
      mbody = 0;
    end
    if (s_tuple_valid) begin
      if (mq.size() < TDEPTH) mq.push_back(s_tuple_data);
      else if (mdrop < 65535) mdrop++;
    end
    if (waiting) begin
      if (mwait < TIMEOUT) mwait++;
      if (mwait >= TIMEOUT) merr = 1;
    end else begin
      mwait = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    arstn = 1'b0; s_tuple_valid = 1'b1; s_tuple_data = rand_tuple();
    s_avalid = 1'b1; s_adata = rand_data(); s_alast = 1'b0; m_aready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (m_avalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_avalid: got %b expected 0", m_avalid); end
    n_checks++; if (s_aready !== 1'b0) begin n_fail++; $display("FAIL reset_s_aready: got %b expected 0", s_aready); end
    n_checks++; if (m_atuser !== '0) begin n_fail++; $display("FAIL reset_m_atuser: got %h expected 0", m_atuser); end
    n_checks++; if (fifo_level !== LW'(0) || drop_cnt !== 16'd0 || err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: got level=%0d drop=%0d err=%b expected 0/0/0", fifo_level, drop_cnt, err_timeout);
    end
    s_tuple_valid = 1'b0; s_avalid = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
  endtask

  task automatic test_basic_packet();
    logic [TUPLE_W-1:0] t;
    t = {16{8'hA5}};
    s_tuple_valid = 1'b1; s_tuple_data = t;
    tick();
    s_tuple_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      s_avalid = 1'b1; s_alast = (b == 2); s_adata = rand_data(); m_aready = 1'b1;
      #1;
      n_checks++; if (m_avalid !== 1'b1 || s_aready !== 1'b1) begin
        n_fail++; $display("FAIL basic_beat%0d_handshake: got valid=%b ready=%b expected 1/1", b, m_avalid, s_aready);
      end
      n_checks++; if (m_atuser !== t) begin n_fail++; $display("FAIL basic_beat%0d_tuser: got %h expected %h", b, m_atuser, t); end
      n_checks++; if (fifo_level !== LW'(b == 0 ? 1 : 0)) begin
        n_fail++; $display("FAIL basic_beat%0d_level: got %0d expected %0d", b, fifo_level, (b == 0 ? 1 : 0));
      end
      n_checks++; if (m_adata !== s_adata || m_alast !== s_alast) begin
        n_fail++; $display("FAIL basic_beat%0d_passthru: got last=%b expected %b", b, m_alast, s_alast);
      end
      tick();
    end
    s_avalid = 1'b1; s_alast = 1'b0;
    #1;
    n_checks++; if (m_avalid !== 1'b0) begin n_fail++; $display("FAIL basic_back_in_sop: got m_avalid=%b expected 0", m_avalid); end
    s_avalid = 1'b0;
  endtask

  task automatic test_wait_for_tuple();
    logic [TUPLE_W-1:0] t;
    t = rand_tuple();
    s_avalid = 1'b1; s_alast = 1'b1; s_adata = rand_data(); m_aready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (m_avalid !== 1'b0) begin n_fail++; $display("FAIL wait_hold%0d: got m_avalid=%b expected 0", i, m_avalid); end
      tick();
    end
    s_tuple_valid = 1'b1; s_tuple_data = t;
    #1;
    n_checks++; if (m_avalid !== 1'b0) begin n_fail++; $display("FAIL wait_push_cycle: got m_avalid=%b expected 0", m_avalid); end
    tick();
    s_tuple_valid = 1'b0;
    #1;
    n_checks++; if (m_avalid !== 1'b1 || m_atuser !== t) begin
      n_fail++; $display("FAIL wait_release: got valid=%b tuser=%h expected 1/%h", m_avalid, m_atuser, t);
    end
    tick();
    s_avalid = 1'b0;
    #1;
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL wait_no_err: got %b expected 0", err_timeout); end
  endtask

  task automatic test_overflow_drop();
    logic [TUPLE_W-1:0] tv [5];
    for (int i = 0; i < 5; i++) begin
      tv[i] = rand_tuple();
      s_tuple_valid = 1'b1; s_tuple_data = tv[i];
      tick();
    end
    s_tuple_valid = 1'b0;
    #1;
    n_checks++; if (fifo_level !== LW'(4) || drop_cnt !== 16'd1) begin
      n_fail++; $display("FAIL overflow_status: got level=%0d drop=%0d expected 4/1", fifo_level, drop_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      s_avalid = 1'b1; s_alast = 1'b1; s_adata = rand_data(); m_aready = 1'b1;
      #1;
      n_checks++; if (m_avalid !== 1'b1 || m_atuser !== tv[i]) begin
        n_fail++; $display("FAIL overflow_order%0d: got valid=%b tuser=%h expected 1/%h", i, m_avalid, m_atuser, tv[i]);
      end
      tick();
    end
    s_avalid = 1'b0;
    #1;
    n_checks++; if (fifo_level !== LW'(0)) begin n_fail++; $display("FAIL overflow_drained: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_full_push_pop();
    logic [TUPLE_W-1:0] tv [5];
    for (int i = 0; i < 4; i++) begin
      tv[i] = rand_tuple();
      s_tuple_valid = 1'b1; s_tuple_data = tv[i];
      tick();
    end
    tv[4] = rand_tuple();
    s_tuple_data = tv[4]; s_avalid = 1'b1; s_alast = 1'b1; m_aready = 1'b1;
    #1;
    n_checks++; if (m_atuser !== tv[0] || s_aready !== 1'b1) begin
      n_fail++; $display("FAIL fullpp_head: got tuser=%h ready=%b expected %h/1", m_atuser, s_aready, tv[0]);
    end
    tick();
    s_tuple_valid = 1'b0; s_avalid = 1'b0;
    #1;
    n_checks++; if (fifo_level !== LW'(4) || drop_cnt !== 16'd1) begin
      n_fail++; $display("FAIL fullpp_status: got level=%0d drop=%0d expected 4/1", fifo_level, drop_cnt);
    end
    for (int i = 1; i < 5; i++) begin
      s_avalid = 1'b1; s_alast = 1'b1;
      #1;
      n_checks++; if (m_avalid !== 1'b1 || m_atuser !== tv[i]) begin
        n_fail++; $display("FAIL fullpp_order%0d: got valid=%b tuser=%h expected 1/%h", i, m_avalid, m_atuser, tv[i]);
      end
      tick();
    end
    s_avalid = 1'b0;
  endtask

  task automatic test_random();
    int  beats_left;
    bit  xfer;
    beats_left = 0;
    for (int c = 0; c < 800; c++) begin
      if (!s_avalid && ($urandom % 3 != 0)) begin
        if (beats_left == 0) beats_left = $urandom_range(1, 4);
        s_avalid = 1'b1; s_adata = rand_data(); s_alast = (beats_left == 1);
      end
      m_aready      = ($urandom % 4 != 0);
      s_tuple_valid = ($urandom % 3 == 0);
      s_tuple_data  = rand_tuple();
      #1;
      calc();
      n_checks++; if (m_avalid !== exp_mvalid || s_aready !== exp_sready || m_atuser !== exp_tuser || m_adata !== s_adata) begin
        n_fail++; $display("FAIL rand_outputs c=%0d: got valid=%b ready=%b tuser=%h expected %b/%b/%h", c, m_avalid, s_aready, m_atuser, exp_mvalid, exp_sready, exp_tuser);
      end
      n_checks++; if (fifo_level !== LW'(mq.size()) || drop_cnt !== 16'(mdrop) || err_timeout !== merr) begin
        n_fail++; $display("FAIL rand_status c=%0d: got level=%0d drop=%0d err=%b expected %0d/%0d/%b", c, fifo_level, drop_cnt, err_timeout, mq.size(), mdrop, merr);
      end
      xfer = s_avalid && exp_sready;
      tick();
      if (xfer) begin
        s_avalid = 1'b0;
        beats_left--;
      end
    end
    s_avalid = 1'b0; s_tuple_valid = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    logic [TUPLE_W-1:0] t;
    arstn = 1'b0; @(negedge clk); arstn = 1'b1; model_reset();
    for (int i = 0; i < 5; i++) begin
      s_tuple_valid = 1'b1; s_tuple_data = rand_tuple();
      tick();
    end
    s_tuple_valid = 1'b0;
    s_avalid = 1'b1; s_alast = 1'b0; m_aready = 1'b1; s_adata = rand_data();
    tick();
    #1;
    n_checks++; if (drop_cnt !== 16'd1 || m_avalid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got drop=%0d valid=%b expected 1/1", drop_cnt, m_avalid);
    end
    #1 arstn = 1'b0;
    #1;
    n_checks++; if (m_avalid !== 1'b0 || fifo_level !== LW'(0) || drop_cnt !== 16'd0 || m_atuser !== '0) begin
      n_fail++; $display("FAIL rstmid_async: got valid=%b level=%0d drop=%0d expected 0/0/0", m_avalid, fifo_level, drop_cnt);
    end
    model_reset();
    @(negedge clk);
    arstn = 1'b1; s_alast = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (m_avalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_held%0d: got m_avalid=%b expected 0", i, m_avalid); end
      tick();
    end
    t = rand_tuple();
    s_tuple_valid = 1'b1; s_tuple_data = t;
    tick();
    s_tuple_valid = 1'b0;
    #1;
    n_checks++; if (m_avalid !== 1'b1 || m_atuser !== t) begin
      n_fail++; $display("FAIL rstmid_head: got valid=%b tuser=%h expected 1/%h", m_avalid, m_atuser, t);
    end
    tick();
    s_avalid = 1'b0;
  endtask

  task automatic test_timeout();
    logic [TUPLE_W-1:0] t;
    s_avalid = 1'b1; s_alast = 1'b0; m_aready = 1'b1; s_adata = rand_data();
    repeat (TIMEOUT - 1) tick();
    #1;
    n_checks++; if (err_timeout !== 1'b0 || m_avalid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: got err=%b valid=%b expected 0/0", err_timeout, m_avalid);
    end
    tick();
    #1;
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b expected 1", err_timeout); end
    t = rand_tuple();
    s_tuple_valid = 1'b1; s_tuple_data = t;
    tick();
    s_tuple_valid = 1'b0;
    #1;
    n_checks++; if (m_avalid !== 1'b1 || m_atuser !== t) begin
      n_fail++; $display("FAIL timeout_release: got valid=%b tuser=%h expected 1/%h", m_avalid, m_atuser, t);
    end
    tick();
    s_alast = 1'b1;
    tick();
    s_avalid = 1'b0;
    #1;
    n_checks++; if (err_timeout !== 1'b1 || err_timeout !== merr) begin
      n_fail++; $display("FAIL timeout_sticky: got %b expected 1", err_timeout);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish expected finish before limit");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_basic_packet();
    test_wait_for_tuple();
    test_overflow_drop();
    test_full_push_pop();
    test_random();
    test_reset_mid_packet();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tuser_sched.md
# tuser_sched

Per-packet tuple scheduler between the SDNet engine and the AXIS output path. It queues the 128-bit tuples the engine emits and holds each AXIS packet at its first beat until a tuple is available. It then stamps that tuple onto `m_atuser` for every beat of the packet. It feeds the tuser output stage and guarantees one tuple per packet, in order.

## Interface
- `DATA_W`, 256, AXIS data width
- `TUPLE_W`, 128, tuple / tuser width
- `TDEPTH`, 4, tuple FIFO depth; power of 2, at least 2
- `TIMEOUT`, 1023, cycles a head beat may wait for a tuple before `err_timeout` sets
- `tsch_aclk`  in  1  sole clock; all state on rising edge
- `tsch_arstn`  in  1  asynchronous active-low reset
- `s_tuple_valid`  in  1  one-cycle tuple strobe from SDNet; no backpressure
- `s_tuple_data`  in  TUPLE_W  tuple payload
- `s_avalid`  in  1  upstream AXIS valid
- `s_aready`  out  1  upstream AXIS ready
- `s_adata`  in  DATA_W  upstream data
- `s_alast`  in  1  upstream end of packet
- `m_avalid`  out  1  downstream valid
- `m_aready`  in  1  downstream ready
- `m_adata`  out  DATA_W  equals `s_adata`
- `m_alast`  out  1  equals `s_alast`
- `m_atuser`  out  TUPLE_W  tuple for the current packet
- `fifo_level`  out  clog2(TDEPTH)+1  tuples queued
- `drop_cnt`  out  16  tuples dropped on full FIFO; saturates at 0xFFFF
- `err_timeout`  out  1  sticky; cleared only by reset

## Operation
- **FSM states:** SOP (the next beat is a packet head) and BODY.
- **gate:** 1 in BODY; in SOP, 1 only when `fifo_level` is not 0.
- **Handshake outputs:**
  - `m_avalid` = `s_avalid` & gate
  - `s_aready` = `m_aready` & gate
  - A beat transfers when `s_avalid` & `s_aready`.
- **`m_atuser`:**
  - In SOP: the FIFO head, or 0 when the FIFO is empty.
  - In BODY: `cur_tuple`.
- **Head transfer in SOP:**
  - Pop the FIFO and load `cur_tuple` with the head.
  - If `s_alast`=1 (single-beat packet), stay in SOP; otherwise go to BODY.
- **BODY:** a transfer with `s_alast`=1 returns to SOP; other transfers leave state unchanged.
- **FIFO push:**
  - A tuple is pushed on `s_tuple_valid` when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the tuple is discarded and `drop_cnt` increments, saturating at 0xFFFF.
- **Simultaneous push and pop:** `fifo_level` is unchanged and both operations take effect. There is no bypass; a tuple pushed into an empty FIFO becomes the head the next cycle.
- **Watchdog:** `wait_cnt` counts cycles in SOP with `s_avalid`=1 and the FIFO empty, and clears in any other cycle. When it reaches `TIMEOUT`, `err_timeout` sets and stays set. The packet remains held; nothing is dropped.
- **Width rules:**
  - FIFO pointers are clog2(TDEPTH) bits and wrap naturally.
  - `fifo_level` ranges from 0 to TDEPTH.
  - `wait_cnt` is clog2(TIMEOUT+1) bits and does not wrap past `TIMEOUT`.

## Timing
- **Reset values (asynchronous):**
  - State SOP; FIFO empty, `fifo_level`=0.
  - `cur_tuple`=0, `drop_cnt`=0, `err_timeout`=0, `wait_cnt`=0.
  - Consequently `m_avalid`=0, `s_aready`=0 and `m_atuser`=0 during reset.
- **Reset release:** release is synchronised by the system; the block acts on the first rising edge after deassertion.
- **Datapath latency:** zero cycles from `s_*` to `m_*` (combinational); `m_adata` and `m_alast` pass straight through.
- **Tuple latency:** 1 cycle from `s_tuple_valid` to usable FIFO head, so a held head beat is released the cycle after its tuple arrives.
- **Reset mid-packet:** the packet is abandoned. The upstream source must also be reset; after reset the first beat is treated as a head.
- **AXIS rules:**
  - `m_avalid` never depends on `m_aready`.
  - Once asserted, `m_avalid` stays up until transfer, because the gate cannot close while the FIFO head waits.

## Test plan
- Tuple 0xA5..A5 pushed, then a 3-beat packet with `m_aready`=1 → 3 transfers in consecutive cycles, `m_atuser`=0xA5..A5 on every beat, `fifo_level` goes 1→0 on the head transfer, state returns to SOP after beat 3.
- Head beat presented with the FIFO empty, tuple arrives 5 cycles later → `m_avalid`=0 for those 5 cycles and the cycle of the push, head transfers on the next cycle, `err_timeout` stays 0.
- Five tuples pushed back-to-back with `TDEPTH`=4 and no packets → `fifo_level`=4, `drop_cnt`=1; then four 1-beat packets → tuples emitted in push order, `fifo_level`=0.
- FIFO full while a head transfer and `s_tuple_valid` occur in the same cycle → push accepted, `drop_cnt` unchanged, `fifo_level` stays 4.
- Head beat held with no tuple for `TIMEOUT` cycles → `err_timeout`=1 and stays 1 after a tuple arrives and the packet completes.
- `tsch_arstn` pulsed low mid-packet (in BODY) → immediately `m_avalid`=0, `fifo_level`=0, `drop_cnt`=0; the next beat after release is held as a head.
